// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared constants and state encoding for the elastic pipeline-stage register.
package pipe_stage_skid_reg_pkg;

   localparam int unsigned ADDRESS_LEN_DEF = 32;
   localparam int unsigned PAYLOAD_W_DEF   = 64;
   localparam int unsigned CNT_W_DEF       = 16;

   // Occupancy of the stage: nothing, main slot only, main + skid slot.
   typedef enum logic [1:0] {
      STG_EMPTY = 2'd0,
      STG_ONE   = 2'd1,
      STG_TWO   = 2'd2
   } stg_state_e;

endpackage

// File: rtl/pipe_stage_skid_reg_slot.sv
// Single register entry: data plus valid flag, with load, clear-valid and async reset.
// Clearing only drops the valid flag; the stored data is left untouched.
module pipe_slot #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic         valid_o,
   output logic [W-1:0] q_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Entry register; clear-valid wins over load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= d_i;
      end
   end

   assign valid_o = valid_q;
   assign q_o     = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register carrying PC + payload with a 2-entry skid buffer,
// global freeze/flush, and saturating stall/flush statistics counters.
module pipe_stage_skid_reg
   import pipe_stage_skid_reg_pkg::*;
#(
   parameter int unsigned ADDRESS_LEN = ADDRESS_LEN_DEF,
   parameter int unsigned PAYLOAD_W   = PAYLOAD_W_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   freeze,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDRESS_LEN-1:0] in_pc,
   input  logic [PAYLOAD_W-1:0]   in_payload,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDRESS_LEN-1:0] out_pc,
   output logic [PAYLOAD_W-1:0]   out_payload,
   output logic [CNT_W-1:0]       stall_cnt,
   output logic [CNT_W-1:0]       flush_cnt
);

   localparam int unsigned SW = ADDRESS_LEN + PAYLOAD_W;

   stg_state_e     state_q, state_d;
   logic           main_load, main_clr, skid_load, skid_clr, main_from_skid;
   logic [SW-1:0]  main_d, main_q, skid_q;
   logic           main_valid, skid_valid;
   logic           push, pop;
   logic           stall_hit;
   logic [1:0]     n_kill;
   logic [CNT_W:0] stall_sum, flush_sum;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   // Handshake depends on registered state only; no path from out_ready to in_ready.
   assign in_ready  = (state_q != STG_TWO) && !freeze && !rst;
   assign out_valid = main_valid;
   assign push      = in_valid && in_ready;
   assign pop       = main_valid && out_ready && !freeze;

   assign main_d      = main_from_skid ? skid_q : {in_pc, in_payload};
   assign out_pc      = main_q[SW-1 -: ADDRESS_LEN];
   assign out_payload = main_q[PAYLOAD_W-1:0];

   pipe_slot #(.W(SW)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load_i  (main_load),
      .clr_i   (main_clr),
      .d_i     (main_d),
      .valid_o (main_valid),
      .q_o     (main_q)
   );

   pipe_slot #(.W(SW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clr_i   (skid_clr),
      .d_i     ({in_pc, in_payload}),
      .valid_o (skid_valid),
      .q_o     (skid_q)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= STG_EMPTY;
      else     state_q <= state_d;
   end

   // Next state and slot controls; flush overrides freeze, freeze overrides push/pop.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clr       = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d  = STG_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else if (!freeze) begin
         unique case (state_q)
            STG_EMPTY: begin
               if (push) begin
                  state_d   = STG_ONE;
                  main_load = 1'b1;
               end
            end
            STG_ONE: begin
               if (push && pop) begin
                  main_load = 1'b1;
               end else if (push) begin
                  state_d   = STG_TWO;
                  skid_load = 1'b1;
               end else if (pop) begin
                  state_d  = STG_EMPTY;
                  main_clr = 1'b1;
               end
            end
            STG_TWO: begin
               if (pop) begin
                  state_d        = STG_ONE;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
               end
            end
            default: begin
               state_d  = STG_EMPTY;
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   // Saturating counter updates; one extra bit catches the carry out.
   always_comb begin
      stall_hit = main_valid && (!out_ready || freeze);
      n_kill    = flush ? ({1'b0, main_valid} + {1'b0, skid_valid}) : 2'd0;
      stall_sum = {1'b0, stall_cnt_q} + (CNT_W + 1)'(stall_hit);
      flush_sum = {1'b0, flush_cnt_q} + (CNT_W + 1)'(n_kill);
      stall_cnt_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
      flush_cnt_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
   end

   // Statistics counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
